// File: rtl/display_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with double-buffered value load.
// Latency: Anodes/Segments/FrameTick registered, one cycle behind the scan counters.
// Backpressure: Ready low while pending holds an unshown value; it clears at the next frame wrap.
//
// Ports:
//   Clock, Reset      - single rising-edge clock, asynchronous active-high reset
//   Load, Value       - write strobe and 16-bit value (digit0 = Value[3:0])
//   Ready             - pending register empty, a Load will be accepted
//   Segments, Anodes  - active-low {g,f,e,d,c,b,a} and active-low one-hot digit enables
//   FrameTick         - one-cycle pulse following each frame wrap
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module display_scan_driver #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] Value,
    output logic        Ready,
    output logic [6:0]  Segments,
    output logic [3:0]  Anodes,
    output logic        FrameTick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    state_t        state_q, state_d;
    logic [15:0]   act_q;
    logic [15:0]   pend_q;
    logic          pend_vld_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          tick_q;

    logic          slot_end;
    logic          wrap;
    logic          accept;
    logic [3:0]    nibble;
    logic [6:0]    seg_show;
    logic [3:0]    an_show;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        wrap     = slot_end && (dig_q == 2'd3);
        accept   = Load && !pend_vld_q;
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        dig_d    = slot_end ? dig_q + 2'd1 : dig_q;
        // State tracks the counter value of the cycle it is held in, so every
        // slot (counter back at 0) starts blanked.
        state_d  = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
        nibble   = act_q[{dig_q, 2'b00} +: 4];
        seg_show = hex7(nibble);
        an_show  = ~(4'b0001 << dig_q);
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is dark when it and every more significant nibble are zero.
        case (dig_q)
            2'd3:    if (act_q[15:12] == 4'h0)  seg_show = 7'b1111111;
            2'd2:    if (act_q[15:8]  == 8'h00) seg_show = 7'b1111111;
            2'd1:    if (act_q[15:4]  == 12'h0) seg_show = 7'b1111111;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= '0;
            dig_q      <= 2'd0;
            state_q    <= ST_BLANK;
            act_q      <= 16'h0000;
            pend_q     <= 16'h0000;
            pend_vld_q <= 1'b0;
            seg_q      <= 7'b1111111;
            an_q       <= 4'b1111;
            tick_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            state_q <= state_d;
            tick_q  <= wrap;
            if (state_q == ST_BLANK) begin
                an_q  <= 4'b1111;
                seg_q <= 7'b1111111;
            end else begin
                an_q  <= an_show;
                seg_q <= seg_show;
            end
            // The output register for the last digit3 cycle samples act_q
            // before this edge, so the swap lands exactly on a frame boundary.
            if (wrap && pend_vld_q) begin
                act_q      <= pend_q;
                pend_vld_q <= 1'b0;
            end
            // Accept only when empty, so it never collides with a transfer;
            // a load on the wrap edge itself waits for the following wrap.
            if (accept) begin
                pend_q     <= Value;
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign Ready     = ~pend_vld_q;
    assign Segments  = seg_q;
    assign Anodes    = an_q;
    assign FrameTick = tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized and directed bench for display_scan_driver against a timeline reference model.
// Latency: expected outputs derived from the cycle index since reset release.
// Backpressure: Ready predicted from the model's pending occupancy.
module tb_display_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Load;
    logic [15:0] Value;
    logic        Ready;
    logic [6:0]  Segments;
    logic [3:0]  Anodes;
    logic        FrameTick;

    always #5 Clock = ~Clock;

    display_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (Load),
        .Value     (Value),
        .Ready     (Ready),
        .Segments  (Segments),
        .Anodes    (Anodes),
        .FrameTick (FrameTick)
    );

    int          tests = 0;
    int          fails = 0;
    int          t;          // index of the current cycle since reset release
    logic [15:0] m_act;
    logic [15:0] m_pend;
    bit          m_pfull;
    int          ticks;
    logic [6:0]  hex_tab [16];
    logic [6:0]  seen [4];   // last segments observed per enabled digit

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [15:0] hi;
        hi = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && hi == 16'h0) return 7'b1111111;
`endif
        return hex_tab[hi[3:0]];
    endfunction

    // One clock: the outputs after the edge describe the cycle that just ended.
    task automatic step();
        logic        ld;
        logic [15:0] val;
        int          d;
        bit          blank, wrapc, old_pf;
        logic [3:0]  ea;
        logic [6:0]  es;
        ld  = Load;
        val = Value;
        @(posedge Clock);
        blank = (t % DIV) < BLANK;
        d     = (t / DIV) % 4;
        ea    = blank ? 4'b1111 : ~(4'(1) << d);
        es    = blank ? 7'b1111111 : exp_seg(m_act, d);
        wrapc = (t % FRAME) == FRAME - 1;
        old_pf = m_pfull;
        if (wrapc && old_pf) begin
            m_act   = m_pend;
            m_pfull = 1'b0;
        end
        if (ld && !old_pf) begin
            m_pend  = val;
            m_pfull = 1'b1;
        end
        t++;
        #1;
        check("anodes",    32'(Anodes),    32'(ea));
        check("segments",  32'(Segments),  32'(es));
        check("frametick", 32'(FrameTick), 32'(wrapc));
        check("ready",     32'(Ready),     32'(!m_pfull));
        if (FrameTick) ticks++;
        for (int k = 0; k < 4; k++)
            if (Anodes == ~(4'(1) << k)) seen[k] = Segments;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int phase);
        while ((t % FRAME) != phase) step();
    endtask

    task automatic clear_seen();
        for (int k = 0; k < 4; k++) seen[k] = 7'h00;
    endtask

    task automatic do_reset();
        Load  = 1'b0;
        Reset = 1'b1;
        #1;
        check("rst_anodes",    32'(Anodes),    32'h0000000F);
        check("rst_segments",  32'(Segments),  32'h0000007F);
        check("rst_ready",     32'(Ready),     32'h1);
        check("rst_frametick", 32'(FrameTick), 32'h0);
        @(posedge Clock);
        #1;
        check("rst_hold_anodes", 32'(Anodes), 32'h0000000F);
        @(negedge Clock);
        Reset   = 1'b0;
        t       = 0;
        m_act   = 16'h0000;
        m_pend  = 16'h0000;
        m_pfull = 1'b0;
        ticks   = 0;
    endtask

    initial begin
        hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
        hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
        hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
        hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
        hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
        hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
        hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
        hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
        Value = 16'h0000;
        Load  = 1'b0;
        t     = 0;
        clear_seen();
        do_reset();

        // Free-running scan after release: two frames, two ticks.
        run(2 * FRAME);
        check("frame_ticks", 32'(ticks), 32'd2);

        // Mid-frame load, then a load while full that must be dropped.
        run_to(12);
        Value = 16'h1A2F;
        Load  = 1'b1;
        step();
        Load  = 1'b0;
        check("ready_low_after_load", 32'(Ready), 32'h0);
        run(4);
        Value = 16'hFFFF;
        Load  = 1'b1;
        step();
        Load  = 1'b0;
        run_to(0);
        check("ready_high_after_wrap", 32'(Ready), 32'h1);
        clear_seen();
        run(FRAME);
        check("d0_1a2f", 32'(seen[0]), 32'(7'b0001110));
        check("d1_1a2f", 32'(seen[1]), 32'(7'b0100100));
        check("d2_1a2f", 32'(seen[2]), 32'(7'b0001000));
        check("d3_1a2f", 32'(seen[3]), 32'(7'b1111001));

        // Load on the wrap cycle: takes effect only one frame later.
        run_to(FRAME - 1);
        Value = 16'h0005;
        Load  = 1'b1;
        step();
        Load  = 1'b0;
        clear_seen();
        run(FRAME);
        check("wrap_load_not_yet", 32'(seen[0]), 32'(7'b0001110));
        clear_seen();
        run(FRAME);
        check("wrap_load_active", 32'(seen[0]), 32'(7'b0010010));

        // Reset during digit 2 display, with a load pending.
        run_to(3);
        Value = 16'h7777;
        Load  = 1'b1;
        step();
        Load  = 1'b0;
        run_to(20);
        check("digit2_showing", 32'(Anodes), 32'(4'b1011));
        do_reset();
        run(DIV + 4);

        // Leading-zero pattern.
        run_to(3);
        Value = 16'h0050;
        Load  = 1'b1;
        step();
        Load  = 1'b0;
        run_to(0);
        clear_seen();
        run(FRAME);
        check("lz_d1", 32'(seen[1]), 32'(7'b0010010));
        check("lz_d0", 32'(seen[0]), 32'(7'b1000000));
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d3", 32'(seen[3]), 32'(7'b1111111));
        check("lz_d2", 32'(seen[2]), 32'(7'b1111111));
`else
        check("lz_d3", 32'(seen[3]), 32'(7'b1000000));
        check("lz_d2", 32'(seen[2]), 32'(7'b1000000));
`endif

        // Random loads with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                Load  = ($urandom_range(0, 3) == 0);
                Value = 16'($urandom);
                if ($urandom_range(0, 3) == 0) Value = Value & 16'h00FF;
                step();
            end
        end
        Load = 1'b0;
        run(FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 The block SHALL have parameter DIV, default 100000: clock cycles per digit slot; legal range 4..2^26-1.
REQ-002 The block SHALL have parameter BLANK, default 1000: dead cycles at the start of each slot; legal range 1..DIV-2.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Load, input, 1 bit: write strobe for Value.
REQ-006 The block SHALL have port Value, input, 16 bits: four hex nibbles; digit0 = Value[3:0], digit3 = Value[15:12].
REQ-007 The block SHALL have port Ready, output, 1 bit: high when the pending register can accept a Load.
REQ-008 The block SHALL have port Segments, output, 7 bits: active-low {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have port Anodes, output, 4 bits: active-low one-hot digit enable; bit n drives digit n.
REQ-010 The block SHALL have port FrameTick, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-011 The block SHALL keep a slot counter 0..DIV-1 and a 2-bit digit index; at counter = DIV-1 it SHALL clear the counter and increment the digit index, wrapping 3 -> 0.
REQ-012 The block SHALL run a two-state FSM: BLANK while counter < BLANK, SHOW while BLANK <= counter <= DIV-1; every slot SHALL begin in BLANK.
REQ-013 In BLANK, Anodes SHALL be 4'b1111 and Segments SHALL be 7'b1111111.
REQ-014 In SHOW, the Anodes bit for the current digit SHALL be 0 and all other bits 1; Segments SHALL carry the decoded nibble of that digit from the active register.
REQ-015 Anodes and Segments SHALL be registered outputs, reflecting the state and counter of the previous cycle (one-cycle latency, glitch-free).
REQ-016 Hex decode SHALL use these values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 Handshake: when Load=1 and Ready=1 on a clock edge, Value SHALL be captured into the pending register and Ready SHALL go low on the next cycle.
REQ-018 A Load while Ready=0 SHALL be ignored; the pending contents SHALL be unchanged.
REQ-019 Frame wrap is the cycle where digit index = 3 and counter = DIV-1; on that edge FrameTick SHALL pulse high for exactly one cycle.
REQ-020 On a frame wrap with the pending register full, the pending value SHALL transfer to the active register and Ready SHALL return high on the next cycle.
REQ-021 The displayed value SHALL change only at frame boundaries; no torn frames are allowed.
REQ-022 When Load is accepted in the same cycle as a frame wrap (Ready=1, pending empty), the new value SHALL go to pending and become active at the following wrap, not the current one.

Reset
REQ-023 While Reset is high, the block SHALL asynchronously force: counter=0, digit=0, FSM=BLANK, active=16'h0000, pending empty, Ready=1, Anodes=4'b1111, Segments=7'b1111111, FrameTick=0.
REQ-024 When Reset is asserted mid-slot or mid-handshake, the block SHALL discard the pending value and restart scanning from digit 0 BLANK on the first edge after release.

Configuration
REQ-025 With macro LEADING_ZERO_BLANK_EN defined, in SHOW each digit n in 3..1 SHALL output Segments=7'b1111111 (with its Anodes bit still 0) when its nibble and all higher nibbles of the active value are 0; digit 0 SHALL always be shown.
REQ-026 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be decoded per REQ-016.

Verification (DIV=8, BLANK=2)
REQ-027 The bench SHALL check reset release with no Load: Anodes = 1111 for 2 cycles, then 1110 with Segments = 1000000 for 6 cycles, then digit 1; FrameTick SHALL pulse once every 32 cycles.
REQ-028 The bench SHALL apply Load with Value = 16'h1A2F mid-frame: Ready SHALL go low next cycle; display SHALL stay 0000 until wrap; next frame SHALL show digit0 = 0001110, digit1 = 0100100, digit2 = 0001000, digit3 = 1111001; Ready SHALL go high after wrap.
REQ-029 The bench SHALL apply a second Load of 16'hFFFF while Ready = 0: it SHALL be ignored and the frame after transfer SHALL show 1A2F.
REQ-030 The bench SHALL apply Load of 16'h0005 exactly on a wrap cycle: it SHALL be active only after the next wrap (32 cycles later).
REQ-031 The bench SHALL assert Reset for 1 cycle during digit 2 SHOW: outputs SHALL immediately be 1111 / 1111111, and Ready SHALL be 1; scanning SHALL resume at digit 0.
REQ-032 The bench SHALL check, with LEADING_ZERO_BLANK_EN and active = 16'h0050: digits 3 and 2 SHALL be blank, digit 1 SHALL be 0010010, and digit 0 SHALL be 1000000.
